noc_input_port_buffer: RTL and testbench

- Router input stage that sits directly upstream of the per-output round-robin arbiters.
- Buffers incoming flits in a small FIFO and decodes the destination output port from each head flit.
- Drives a one-hot request toward the selected output's arbiter and holds it, with wormhole locking, from head through tail.
- Forwards flits only while the arbiter grants this input and the downstream link is ready.

---
 rtl/noc_input_port_buffer.sv | 129 ++++++++++++
 tb/tb_noc_input_port_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_port_buffer.sv
// Router input stage: flit FIFO, head-flit destination decode and a wormhole-locked
// one-hot request toward the output arbiters.
module noc_input_port_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int NUM_OUTPUTS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_OUTPUTS-1:0] out_request,
  input  logic                   grant_in,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_flit,
  output logic                   out_valid,
  output logic                   busy,
  output logic [7:0]             drop_count
);

  localparam int DEST_W = $clog2(NUM_OUTPUTS);
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_t;

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;
  logic                  xfer, latch_dest, drop_inc;
  logic [DATA_WIDTH-1:0] head;
  flit_t                 head_type;
  logic [DEST_W-1:0]     dest;
  state_t                state, next_state;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_type = flit_t'(head[DATA_WIDTH-1 -: 2]);

  // Storage is cleared on reset so out_flit is never X, even when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= in_flit;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dest       <= '0;
      drop_count <= '0;
    end else begin
      state <= next_state;
      if (latch_dest) dest <= head[DEST_W-1:0];
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    xfer       = 1'b0;
    latch_dest = 1'b0;
    drop_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (head_type == FT_HEAD || head_type == FT_SINGLE) begin
            latch_dest = 1'b1;
            next_state = REQ;
          end else begin
            pop      = 1'b1;
            drop_inc = 1'b1;
          end
        end
      end
      REQ: begin
        if (grant_in && out_ready && !empty) begin
          xfer       = 1'b1;
          pop        = 1'b1;
          next_state = (head_type == FT_SINGLE) ? IDLE : SEND;
        end
      end
      SEND: begin
        if (!empty) begin
          // A new head mid-packet closes the current one without consuming it.
          if (head_type == FT_HEAD || head_type == FT_SINGLE) begin
            drop_inc   = 1'b1;
            next_state = IDLE;
          end else if (grant_in && out_ready) begin
            xfer = 1'b1;
            pop  = 1'b1;
            if (head_type == FT_TAIL) next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request depends only on registered state and dest, so it cannot glitch.
  always_comb begin
    out_request = '0;
    if (state != IDLE) out_request[dest] = 1'b1;
  end

  assign out_valid = xfer;
  assign out_flit  = head;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_noc_input_port_buffer.sv
// Scoreboard bench for noc_input_port_buffer: expected flits are queued at drive
// time and compared against every out_valid pulse.
module tb_noc_input_port_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_request;
  logic        grant_in;
  logic        out_ready;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        busy;
  logic [7:0]  drop_count;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [31:0] sb[$];

  noc_input_port_buffer #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .NUM_OUTPUTS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_request(out_request),
    .grant_in   (grant_in),
    .out_ready  (out_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] d, input logic [27:0] p);
    return {t, p, d};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      pulses++;
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else check("out_flit", out_flit, sb.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 50), 32'd1);
    next_cycle();
  endtask

  task automatic single_test(input logic [1:0] d, input string tag);
    logic [31:0] f;
    logic [3:0]  onehot;
    f      = mk(2'b11, d, 28'(32'h0ABC_0000 + d));
    onehot = 4'b0001 << d;
    grant_in  = 1'b1;
    out_ready = 1'b1;
    in_flit   = f;
    in_valid  = 1'b1;
    sb.push_back(f);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_c1_req"}, 32'(out_request), 32'd0);
    @(negedge clk);
    check({tag, "_c2_req"}, 32'(out_request), 32'(onehot));
    check({tag, "_c2_valid"}, 32'(out_valid), 32'd1);
    @(negedge clk);
    check({tag, "_c3_req"}, 32'(out_request), 32'd0);
    check({tag, "_c3_busy"}, 32'(busy), 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pkt[4];
    logic [31:0] extra;
    logic [3:0]  exp_req;
    logic        rdy_tab[9];
    logic        ir_tab[8];
    int          base;

    rst_n     = 1'b0;
    in_flit   = '0;
    in_valid  = 1'b0;
    grant_in  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req", 32'(out_request), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_flit", out_flit, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    single_test(2'd2, "single");

    // 4-flit packet with a stalled downstream in one cycle
    pkt[0]  = mk(2'b01, 2'd1, 28'h1111111);
    pkt[1]  = mk(2'b00, 2'd2, 28'h2222222);
    pkt[2]  = mk(2'b00, 2'd3, 28'h3333333);
    pkt[3]  = mk(2'b10, 2'd0, 28'h4444444);
    rdy_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    base    = pulses;
    grant_in = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid  = (c < 4);
      out_ready = rdy_tab[c];
      if (c < 4) begin
        in_flit = pkt[c];
        sb.push_back(pkt[c]);
      end
      @(negedge clk);
      if (c >= 2 && c <= 6) check("pkt4_req", 32'(out_request), 32'h2);
      if (c == 3) check("pkt4_stall", 32'(out_valid), 32'd0);
      if (c >= 7) check("pkt4_req_drop", 32'(out_request), 32'd0);
      next_cycle();
    end
    in_valid = 1'b0;
    check("pkt4_pulses", 32'(pulses - base), 32'd4);

    // Fill with grant low; a fifth flit must be refused
    pkt[0]   = mk(2'b01, 2'd3, 28'h5550001);
    pkt[1]   = mk(2'b00, 2'd0, 28'h5550002);
    pkt[2]   = mk(2'b00, 2'd1, 28'h5550003);
    pkt[3]   = mk(2'b10, 2'd2, 28'h5550004);
    extra    = mk(2'b11, 2'd0, 28'h5550005);
    ir_tab   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      grant_in = (c >= 6);
      in_valid = (c < 5);
      if (c < 4) begin
        in_flit = pkt[c];
        sb.push_back(pkt[c]);
      end else begin
        in_flit = extra;
      end
      @(negedge clk);
      check($sformatf("full_in_ready_c%0d", c), 32'(in_ready), 32'(ir_tab[c]));
      if (c == 5) check("full_req_hold", 32'(out_request), 32'h8);
      next_cycle();
    end
    in_valid = 1'b0;
    drain("full_drain");
    idle_cycles(3);

    // Orphan tail and body while idle
    grant_in  = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_flit   = mk(2'b10, 2'd1, 28'h0DEAD01);
    next_cycle();
    in_flit   = mk(2'b00, 2'd2, 28'h0DEAD02);
    next_cycle();
    in_valid  = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    check("orphan_drop", 32'(drop_count), 32'd2);
    check("orphan_busy", 32'(busy), 32'd0);
    next_cycle();

    // Malformed: a second head arrives mid-packet
    pkt[0] = mk(2'b01, 2'd0, 28'h6660001);
    pkt[1] = mk(2'b00, 2'd1, 28'h6660002);
    pkt[2] = mk(2'b01, 2'd3, 28'h6660003);
    pkt[3] = mk(2'b10, 2'd2, 28'h6660004);
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 4);
      if (c < 4) begin
        in_flit = pkt[c];
        sb.push_back(pkt[c]);
      end
      @(negedge clk);
      if (c >= 2) begin
        exp_req = (c <= 4) ? 4'b0001 : (c == 6 || c == 7) ? 4'b1000 : 4'b0000;
        check($sformatf("malf_req_c%0d", c), 32'(out_request), 32'(exp_req));
      end
      if (c == 4) check("malf_no_valid", 32'(out_valid), 32'd0);
      if (c == 5) check("malf_drop", 32'(drop_count), 32'd3);
      next_cycle();
    end
    in_valid = 1'b0;
    drain("malf_drain");

    // Drop counter saturation
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_flit = mk(2'b00, 2'(i), 28'(i));
      next_cycle();
    end
    in_valid = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    check("drop_saturate", 32'(drop_count), 32'd255);
    next_cycle();

    // Asynchronous reset while a packet is mid-transfer
    pkt[0] = mk(2'b01, 2'd1, 28'h7770001);
    pkt[1] = mk(2'b00, 2'd0, 28'h7770002);
    pkt[2] = mk(2'b00, 2'd0, 28'h7770003);
    pkt[3] = mk(2'b00, 2'd0, 28'h7770004);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_flit  = pkt[c];
      sb.push_back(pkt[c]);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_busy", 32'(busy), 32'd1);
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(out_request), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_drop", 32'(drop_count), 32'd0);
    sb.delete();
    next_cycle();
    rst_n = 1'b1;
    idle_cycles(2);
    single_test(2'd3, "post_rst");

    idle_cycles(4);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
